// File: rtl/wb_stage.sv
// Memory/write-back pipeline register and write-back source selection.
// Drives the GRF write port and exports forwarding info for the hazard unit.
module wb_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] m_pc,
    input  logic        m_we,
    input  logic [4:0]  m_regAddr,
    input  logic [1:0]  m_wbSel,
    input  logic [2:0]  m_memType,
    input  logic [31:0] m_aluOut,
    input  logic [31:0] m_memRead,
    input  logic [31:0] m_hilo,
    output logic [31:0] pc,
    output logic        WE,
    output logic [4:0]  regAddr,
    output logic [31:0] regData,
    output logic        fwdValid
);

    localparam int unsigned W_XLEN = 32;
    localparam int unsigned W_ADDR = 5;
    localparam int unsigned W_SEL  = 2;
    localparam int unsigned W_TYPE = 3;

    localparam logic [W_SEL-1:0]  SEL_ALU  = 2'b00;
    localparam logic [W_SEL-1:0]  SEL_LOAD = 2'b01;
    localparam logic [W_SEL-1:0]  SEL_LINK = 2'b10;
    localparam logic [W_SEL-1:0]  SEL_HILO = 2'b11;

    localparam logic [W_TYPE-1:0] MT_LB  = 3'b001;
    localparam logic [W_TYPE-1:0] MT_LBU = 3'b010;
    localparam logic [W_TYPE-1:0] MT_LH  = 3'b011;
    localparam logic [W_TYPE-1:0] MT_LHU = 3'b100;

    logic [W_XLEN-1:0] r_pc;
    logic              r_we;
    logic [W_ADDR-1:0] r_addr;
    logic [W_SEL-1:0]  r_sel;
    logic [W_TYPE-1:0] r_type;
    logic [W_XLEN-1:0] r_alu;
    logic [W_XLEN-1:0] r_mem;
    logic [W_XLEN-1:0] r_hilo;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [W_XLEN-1:0] w_ext;
    logic [W_XLEN-1:0] w_link;
    logic [W_XLEN-1:0] w_data;

    // Stage register: reset and flush both load a bubble; flush beats stall.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_pc   <= PC_RESET;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_sel  <= '0;
            r_type <= '0;
            r_alu  <= '0;
            r_mem  <= '0;
            r_hilo <= '0;
        end else if (!stall) begin
            r_pc   <= m_pc;
            r_we   <= m_we;
            r_addr <= m_regAddr;
            r_sel  <= m_wbSel;
            r_type <= m_memType;
            r_alu  <= m_aluOut;
            r_mem  <= m_memRead;
            r_hilo <= m_hilo;
        end
    end

    // Load extension; halfword select ignores offset bit 0.
    always_comb begin
        w_byte = r_mem[7:0];
        w_half = r_alu[1] ? r_mem[31:16] : r_mem[15:0];
        w_ext  = r_mem;
        case (r_alu[1:0])
            2'd0:    w_byte = r_mem[7:0];
            2'd1:    w_byte = r_mem[15:8];
            2'd2:    w_byte = r_mem[23:16];
            default: w_byte = r_mem[31:24];
        endcase
        case (r_type)
            MT_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
            MT_LBU:  w_ext = {24'h00_0000, w_byte};
            MT_LH:   w_ext = {{16{w_half[15]}}, w_half};
            MT_LHU:  w_ext = {16'h0000, w_half};
            default: w_ext = r_mem;
        endcase
    end

    assign w_link = r_pc + W_XLEN'(8);

    always_comb begin
        w_data = r_alu;
        case (r_sel)
            SEL_ALU:  w_data = r_alu;
            SEL_LOAD: w_data = w_ext;
            SEL_LINK: w_data = w_link;
            SEL_HILO: w_data = r_hilo;
            default:  w_data = r_alu;
        endcase
    end

    // $0 is never written, so it is never a forwarding source either.
    assign pc       = r_pc;
    assign regAddr  = r_addr;
    assign WE       = r_we && (r_addr != '0);
    assign fwdValid = WE;
    assign regData  = w_data;

endmodule
